// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// the canonical NOP word and a PC-width helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  // Byte PC width for a given ROM word-address width.
  function automatic int pc_width(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr}. Slot 0 is always the head, so the head
// fields come straight from flops and hold still while nothing pops.
// flush wins over push and pop; a pop on an empty queue is ignored.
module fetch_queue #(
  parameter int DW = 32,
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [PW-1:0] push_pc_i,
  input  logic [DW-1:0] push_instr_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [PW-1:0] head_pc_o,
  output logic [DW-1:0] head_instr_o,
  output logic [1:0]    count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] pc_q    [2];
  logic [PW-1:0] pc_d    [2];
  logic [DW-1:0] instr_q [2];
  logic [DW-1:0] instr_d [2];
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          do_pop;

  // Next-state of slots and occupancy; head stays in slot 0.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != 2'd0);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, do_pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            pc_d[0]    = push_pc_i;
            instr_d[0] = push_instr_i;
          end else begin
            pc_d[0]    = pc_q[1];
            instr_d[0] = instr_q[1];
            pc_d[1]    = push_pc_i;
            instr_d[1] = push_instr_i;
          end
        end
        2'b10: begin
          pc_d[count_q[0]]    = push_pc_i;
          instr_d[count_q[0]] = push_instr_i;
          count_d             = count_q + 2'd1;
        end
        2'b01: begin
          pc_d[0]    = pc_q[1];
          instr_d[0] = instr_q[1];
          count_d    = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      count_q    <= 2'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign head_pc_o    = pc_q[0];
  assign head_instr_o = instr_q[0];
  assign count_o      = count_q;
  assign full_o       = (count_q == 2'd2);
  assign empty_o      = (count_q == 2'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational
// text ROM and buffers {pc, instr} in a 2-entry queue for IF/ID.
// Handshake: the head transfers on a cycle where ifid_valid && ifid_ready;
// while ifid_valid && !ifid_ready the ifid_* outputs hold unchanged.
// Optional build macro FETCH_ZERO_HALT_EN: a zero fetched word halts
// fetching and only a redirect leaves HALT.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH+1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH+1:0] redirect_pc,
  input  logic                  halt_req,
  output logic                  ifid_valid,
  input  logic                  ifid_ready,
  output logic [DATA_WIDTH-1:0] ifid_instr,
  output logic [ADDR_WIDTH+1:0] ifid_pc,
  output logic                  halted,
  output logic [1:0]            dbg_state
);

  localparam int            PW       = pc_width(ADDR_WIDTH);
  localparam logic [PW-1:0] PC_STEP  = PW'(4);
  localparam logic [PW-1:0] PC_RESET = {RESET_PC[PW-1:2], 2'b00};

  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;

  logic          q_full;
  logic          q_empty;
  logic [1:0]    q_count_unused;
  logic [1:0]    unused_redirect_lsb;
  logic          pop;
  logic          space;
  logic          redir;
  logic          fetch_ok;
  logic          push;
  logic          zero_stop;

  assign unused_redirect_lsb = redirect_pc[1:0];

  assign ifid_valid = !q_empty;
  assign pop        = ifid_valid && ifid_ready;
  assign space      = !q_full || pop;
  assign redir      = redirect_valid && (state_q != ST_BOOT);
  assign fetch_ok   = (state_q == ST_RUN) && !redirect_valid && space;

`ifdef FETCH_ZERO_HALT_EN
  assign zero_stop = fetch_ok && (imem_data == '0);
`else
  assign zero_stop = 1'b0;
`endif
  assign push = fetch_ok && !zero_stop;

  // Next state and next PC; redirect has priority over sequential fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redir) begin
      pc_d = {redirect_pc[PW-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req || zero_stop) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
`ifdef FETCH_ZERO_HALT_EN
        if (redirect_valid) begin
          state_d = ST_RUN;
        end
`else
        if (!halt_req || redirect_valid) begin
          state_d = ST_RUN;
        end
`endif
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // FSM state and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .DW (DATA_WIDTH),
    .PW (PW)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_pc_i    (pc_q),
    .push_instr_i (imem_data),
    .pop_i        (pop),
    .flush_i      (redir),
    .head_pc_o    (ifid_pc),
    .head_instr_o (ifid_instr),
    .count_o      (q_count_unused),
    .full_o       (q_full),
    .empty_o      (q_empty)
  );

  assign imem_addr = pc_q[PW-1:2];
  assign halted    = (state_q == ST_HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        ifid_valid;
  logic        ifid_ready = 1'b1;
  logic [31:0] ifid_instr;
  logic [9:0]  ifid_pc;
  logic        halted;
  logic [1:0]  dbg_state;

  // second instance exercising RESET_PC near the top of the address space
  logic [7:0]  w_imem_addr;
  logic [31:0] w_imem_data;
  logic        w_redirect_valid = 1'b0;
  logic [9:0]  w_redirect_pc = '0;
  logic        w_halt_req = 1'b0;
  logic        w_ifid_valid;
  logic        w_ifid_ready = 1'b1;
  logic [31:0] w_ifid_instr;
  logic [9:0]  w_ifid_pc;
  logic        w_halted;
  logic [1:0]  w_dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] frozen_addr;

  // clock
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    case (a)
      8'd0:    return 32'h00500093;
      8'd1:    return 32'h00a00113;
      8'd2:    return 32'h002081b3;
      8'd3:    return 32'h00000013;
      default: return 32'h00000000;
    endcase
  endfunction

  assign imem_data   = rom(imem_addr);
  assign w_imem_data = NOP;

  fetch_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(10'h000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .ifid_valid(ifid_valid), .ifid_ready(ifid_ready),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .halted(halted),
    .dbg_state(dbg_state)
  );

  fetch_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(10'h3FC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .halt_req(w_halt_req), .ifid_valid(w_ifid_valid), .ifid_ready(w_ifid_ready),
    .ifid_instr(w_ifid_instr), .ifid_pc(w_ifid_pc), .halted(w_halted),
    .dbg_state(w_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    ifid_ready     = ready;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [9:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
    check({tag, "_pc"}, {22'd0, ifid_pc}, {22'd0, pc});
    check({tag, "_instr"}, ifid_instr, instr);
  endtask

  initial begin
    // ---- reset state and sequential fetch ----
    rst_n = 1'b0;
    step();
    step();
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'd0);
    check("rst_pc", {22'd0, ifid_pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_w_addr", {24'd0, w_imem_addr}, 32'h0FF);
    rst_n = 1'b1;
    step();
    check("boot_valid", {31'd0, ifid_valid}, 32'd0);
    check("boot_state", {30'd0, dbg_state}, 32'd1);
    step();
    check_head("seq0", 10'h000, 32'h00500093);
    check("wrap0_pc", {22'd0, w_ifid_pc}, 32'h3FC);
    step();
    check_head("seq1", 10'h004, 32'h00a00113);
    check("wrap1_pc", {22'd0, w_ifid_pc}, 32'h000);
    check("wrap1_valid", {31'd0, w_ifid_valid}, 32'd1);
    step();
    check_head("seq2", 10'h008, 32'h002081b3);
    step();
    check_head("seq3", 10'h00C, 32'h00000013);
    step();
`ifdef FETCH_ZERO_HALT_EN
    check("zero_valid", {31'd0, ifid_valid}, 32'd0);
    check("zero_halted", {31'd0, halted}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 10'h000;
    step();
    redirect_valid = 1'b0;
    check("zredir_halted", {31'd0, halted}, 32'd0);
    check("zredir_valid", {31'd0, ifid_valid}, 32'd0);
    step();
    check_head("zresume", 10'h000, 32'h00500093);
`else
    check_head("zero_word", 10'h010, 32'h00000000);
    check("zero_halted", {31'd0, halted}, 32'd0);
`endif

    // ---- back-pressure: queue fills, PC stalls ----
    do_reset(1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check_head("stall", 10'h000, 32'h00500093);
      if (i > 0) check("stall_addr", {24'd0, imem_addr}, 32'd2);
    end
    ifid_ready = 1'b1;
    step();
    check_head("rel1", 10'h004, 32'h00a00113);
    step();
    check_head("rel2", 10'h008, 32'h002081b3);

    // ---- redirect while two entries are queued ----
    do_reset(1'b0);
    step();
    step();
    step();
    check("pre_redir_addr", {24'd0, imem_addr}, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 10'h00F;
    ifid_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", {31'd0, ifid_valid}, 32'd0);
    check("redir_addr", {24'd0, imem_addr}, 32'd3);
    step();
    check_head("redir_head", 10'h00C, 32'h00000013);

    // ---- halt request: fetch freezes, queue drains ----
    do_reset(1'b0);
    step();
    step();
    halt_req = 1'b1;
    step();
    check("halt_on", {31'd0, halted}, 32'd1);
    check("halt_state", {30'd0, dbg_state}, 32'd2);
    frozen_addr = imem_addr;
    check("halt_addr0", {24'd0, frozen_addr}, 32'd2);
    step();
    check("halt_addr1", {24'd0, imem_addr}, {24'd0, frozen_addr});
    ifid_ready = 1'b1;
    step();
    check_head("drain1", 10'h004, 32'h00a00113);
    check("halt_addr2", {24'd0, imem_addr}, {24'd0, frozen_addr});
    step();
    check("drain_empty", {31'd0, ifid_valid}, 32'd0);
    check("halt_still", {31'd0, halted}, 32'd1);
    halt_req = 1'b0;
    step();
`ifdef FETCH_ZERO_HALT_EN
    check("halt_sticky", {31'd0, halted}, 32'd1);
`else
    check("halt_off", {31'd0, halted}, 32'd0);
    step();
    check_head("resume", 10'h008, 32'h002081b3);
`endif

    // ---- asynchronous reset mid-stream ----
    do_reset(1'b1);
    step();
    step();
    step();
    check("pre_arst_addr", {24'd0, imem_addr}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_pc", {22'd0, ifid_pc}, 32'd0);
    check("arst_instr", ifid_instr, 32'd0);
    check("arst_addr", {24'd0, imem_addr}, 32'd0);
    check("arst_halted", {31'd0, halted}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check_head("arst_restart", 10'h000, 32'h00500093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
